// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control unit.
//   ctrl_state_e : control FSM state encoding
//   REG_W        : architectural register-index width
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID-stage sources and the
// destinations of the instructions in EXE and MEM.
//   src1/src2, use_src1/two_src        : ID-stage operand usage
//   exe_wb_en/exe_dest/exe_mem_r_en    : instruction in EXE
//   mem_wb_en/mem_dest                 : instruction in MEM
//   fwd_en                             : forwarding unit active
//   hazard_c                           : ID instruction must wait one cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             fwd_en,
  output logic             hazard_c
);

  // With forwarding only a load in EXE cannot be bypassed in time.
  function automatic logic match(input logic [REG_W-1:0] s);
    logic exe_hit;
    logic mem_hit;
    exe_hit = exe_wb_en && (exe_dest == s);
    mem_hit = mem_wb_en && (mem_dest == s);
    if (fwd_en) begin
      match = exe_hit && exe_mem_r_en;
    end else begin
      match = exe_hit || mem_hit;
    end
  endfunction

  always_comb begin
    hazard_c = (use_src1 && match(src1)) || (two_src && match(src2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: freeze/flush generation for PC, IF/ID and ID/EX,
// a back-end freeze for memory stalls, a memory-timeout error state, and
// saturating stall/flush performance counters.
//   clk, rst (async, active-low)
//   src*/use_src1/two_src/exe_*/mem_wb_en/mem_dest/fwd_en : hazard inputs
//   branch_taken                : branch resolving in EXE
//   mem_req/mem_ready           : memory controller handshake
//   freeze_pc/freeze_if/flush_if/flush_id/freeze_back : pipeline controls
//   mem_err                     : sticky memory-timeout error
//   stall_cnt/flush_cnt         : saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_back,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_stall_c;
  logic              hazard_c;

  hazard_detect u_hazard_detect (
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .two_src      (two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .fwd_en       (fwd_en),
    .hazard_c     (hazard_c)
  );

  // The cycle mem_ready arrives is not a stall cycle.
  always_comb begin
    mem_stall_c = ((state_q == RUN) && mem_req && !mem_ready) ||
                  ((state_q == MEM_WAIT) && !mem_ready);
  end

  // Next-state logic and wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d    = ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Fixed-priority control muxing: reset, error, memory stall, branch, hazard.
  always_comb begin
    freeze_pc   = 1'b0;
    freeze_if   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    freeze_back = 1'b0;
    if (!rst) begin
      freeze_pc = 1'b0;
    end else if ((state_q == ERR) || mem_stall_c) begin
      freeze_pc   = 1'b1;
      freeze_if   = 1'b1;
      freeze_back = 1'b1;
    end else if (branch_taken) begin
      // A branch held in a frozen EXE flushes here exactly once on release.
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hazard_c) begin
      freeze_pc = 1'b1;
      freeze_if = 1'b1;
      flush_id  = 1'b1;
    end
  end

  // Sticky error flag and saturating counters.
  always_comb begin
    mem_err_d   = mem_err_q || (state_d == ERR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_if && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
